// File: rtl/tt_um_inv_sub_bytes_stream.sv
// Byte-serial AES InvSubBytes engine with 16-byte block framing, last marker and sticky framing error.
// Define INV_SBOX_PIPE_EN to add an input register stage in front of the S-box (latency 2 instead of 1).
module tt_um_inv_sub_bytes_stream #(
  parameter int FRAME_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [3:0] out_idx,
  output logic       frame_err
);

  localparam int            CW       = $clog2(FRAME_BYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BYTES - 1);

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    case (b)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [CW-1:0] r_in_cnt;
  logic          r_frame_err;
  logic [7:0]    r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic [3:0]    r_out_idx;

  logic       w_accept;
  logic       w_at_end;
  logic       w_tag_last;
  logic [3:0] w_tag_idx;
  logic       w_out_ready_int;
  logic       w_load_out;
  logic [7:0] w_load_data;
  logic       w_load_last;
  logic [3:0] w_load_idx;

  // Tagging happens at input accept in both builds, so framing is independent of pipeline depth.
  assign w_accept        = in_valid && in_ready;
  assign w_at_end        = (r_in_cnt == LAST_IDX);
  assign w_tag_last      = w_at_end || in_last;
  assign w_tag_idx       = 4'(r_in_cnt);
  assign w_out_ready_int = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else if (w_accept) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, so block order never matters.
      r_in_cnt <= w_tag_last ? '0 : r_in_cnt + CW'(1);
      if (in_last != w_at_end) r_frame_err <= 1'b1;
    end
  end

`ifdef INV_SBOX_PIPE_EN
  logic [7:0] r_a_data;
  logic       r_a_valid;
  logic       r_a_last;
  logic [3:0] r_a_idx;

  assign in_ready    = !r_a_valid || w_out_ready_int;
  assign w_load_out  = r_a_valid && w_out_ready_int;
  assign w_load_data = inv_sbox(r_a_data);
  assign w_load_last = r_a_last;
  assign w_load_idx  = r_a_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_data  <= 8'h00;
      r_a_last  <= 1'b0;
      r_a_idx   <= 4'd0;
    end else if (w_accept) begin
      r_a_valid <= 1'b1;
      r_a_data  <= in_data;
      r_a_last  <= w_tag_last;
      r_a_idx   <= w_tag_idx;
    end else if (w_load_out) begin
      r_a_valid <= 1'b0;
    end
  end
`else
  assign in_ready    = w_out_ready_int;
  assign w_load_out  = w_accept;
  assign w_load_data = inv_sbox(in_data);
  assign w_load_last = w_tag_last;
  assign w_load_idx  = w_tag_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
      r_out_idx   <= 4'd0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_data;
      r_out_last  <= w_load_last;
      r_out_idx   <= w_load_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_idx   = r_out_idx;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_tt_um_inv_sub_bytes_stream.sv
// Self-checking bench for tt_um_inv_sub_bytes_stream: GF(2^8)-derived S-box model plus a framing scoreboard.
module tb_tt_um_inv_sub_bytes_stream;

`ifdef INV_SBOX_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int FB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [3:0] out_idx;
  logic       frame_err;

  tt_um_inv_sub_bytes_stream #(.FRAME_BYTES(FB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_idx(out_idx), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference S-box built from GF(2^8) arithmetic and the affine map; the inverse is the table inverse.
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  initial begin
    for (int v = 0; v < 256; v++) begin
      logic [7:0] g = 8'h00;
      for (int w = 1; w < 256; w++)
        if (gmul(8'(v), 8'(w)) == 8'h01) g = 8'(w);
      fwd_tab[v] = g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63;
    end
    for (int v = 0; v < 256; v++) inv_tab[fwd_tab[v]] = 8'(v);
  end

  typedef struct packed {
    logic [7:0]  d;
    logic        l;
    logic [3:0]  i;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e_pop;
  exp_t        e_push;
  int          m_cnt;
  logic        m_err;
  logic [31:0] cyc;
  logic        mon_en  = 1'b0;
  logic        chk_lat = 1'b0;
  logic        bp_en   = 1'b0;
  logic        stalled;
  logic [7:0]  h_d;
  logic        h_l;
  logic [3:0]  h_i;

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor samples at the falling edge: the handshakes seen here are those taken at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      check("frame_err", frame_err, m_err);
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, h_d);
        check("hold_last", out_last, h_l);
        check("hold_idx", out_idx, h_i);
      end
`ifndef INV_SBOX_PIPE_EN
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
`endif
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e_pop = q.pop_front();
          check("out_data", out_data, e_pop.d);
          check("out_last", out_last, e_pop.l);
          check("out_idx", out_idx, e_pop.i);
          if (chk_lat) check("latency", cyc - e_pop.cyc, LAT);
        end
      end
      stalled = out_valid && !out_ready;
      h_d = out_data;
      h_l = out_last;
      h_i = out_idx;
      if (in_valid && in_ready) begin
        e_push.d   = inv_tab[in_data];
        e_push.i   = 4'(m_cnt);
        e_push.l   = (m_cnt == FB - 1) || in_last;
        e_push.cyc = cyc;
        q.push_back(e_push);
        if (in_last != (m_cnt == FB - 1)) m_err = 1'b1;
        m_cnt = e_push.l ? 0 : m_cnt + 1;
      end
    end else begin
      q.delete();
      m_cnt   = 0;
      m_err   = 1'b0;
      cyc     = 0;
      stalled = 1'b0;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int   n = 0;
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
    check("drain_idle", out_valid, 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_idx", out_idx, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] kv [6];
    kv = '{8'h63, 8'h7c, 8'h00, 8'hed, 8'h16, 8'h01};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    @(posedge clk);
    #1;
    do_reset();

    // Known vectors at full rate with latency checking.
    chk_lat = 1'b1;
    for (int k = 0; k < 6; k++) send(kv[k], 1'b0);
    drain();
    chk_lat = 1'b0;

    // Sweep: feed SBox(x) for every x so the expected output is x itself; 16 framed blocks.
    do_reset();
    for (int k = 0; k < 256; k++) send(fwd_tab[k], (k % FB) == FB - 1);
    drain();
    check("sweep_no_err", frame_err, 0);

    // Random backpressure over 64 framed random bytes.
    bp_en = 1'b1;
    for (int k = 0; k < 64; k++) send(8'($urandom_range(0, 255)), (k % FB) == FB - 1);
    bp_en = 1'b0;
    drain();

    // Early last on index 9.
    for (int k = 0; k < 10; k++) send(8'($urandom_range(0, 255)), k == 9);
    check("early_err_next_cycle", frame_err, 1);
    for (int k = 0; k < 3; k++) send(8'($urandom_range(0, 255)), 1'b0);
    drain();
    check("early_err_sticky", frame_err, 1);

    // Missing last: 16 bytes with in_last never asserted.
    do_reset();
    for (int k = 0; k < FB; k++) send(8'($urandom_range(0, 255)), 1'b0);
    drain();
    check("missing_last_err", frame_err, 1);

    // Reset mid-block while a byte is held at the output.
    for (int k = 0; k < 7; k++) send(8'($urandom_range(0, 255)), 1'b0);
`ifndef INV_SBOX_PIPE_EN
    check("pre_rst_valid", out_valid, 1);
`endif
    check("pre_rst_err", frame_err, 1);
    do_reset();
    send(8'h63, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
